// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor with a valid/ready operand input and a
// valid/ready result output. DIGIT bits of the operands are consumed LSB-first
// per cycle, so one operation takes WIDTH/DIGIT cycles after capture.
module serial_adder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NSteps = WIDTH / DIGIT;
    localparam int unsigned StepW  = $clog2(NSteps + 1);

    // Reject parameterisations that cannot produce a whole number of digits.
    if (WIDTH < 2 || DIGIT == 0 || (WIDTH % DIGIT) != 0) begin : g_param_check
        $fatal(1, "serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e st_q, st_d;

    // Held low through reset and set on the first clock edge afterwards, so
    // in_ready stays low until the block has seen a clean edge.
    logic ready_en_q;

    logic [WIDTH-1:0] a_q, a_d;  // operand A; also collects sum digits from the top
    logic [WIDTH-1:0] b_q, b_d;  // operand B' (inverted for subtract)
    logic             carry_q, carry_d;
    logic [StepW-1:0] step_q, step_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             capture;
    logic             last_step;
    logic [DIGIT-1:0] sum_dig;
    logic [DIGIT:0]   carry_chain;
    logic [WIDTH-1:0] a_shift;

    assign capture   = (st_q == StIdle) && ready_en_q && in_valid;
    assign last_step = (st_q == StRun) && (step_q == StepW'(NSteps - 1));

    // State register, reset asynchronously to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q       <= StIdle;
            ready_en_q <= 1'b0;
        end else begin
            st_q       <= st_d;
            ready_en_q <= 1'b1;
        end
    end

    // Next-state logic.
    always_comb begin
        st_d = st_q;
        unique case (st_q)
            StIdle:  if (capture) st_d = StRun;
            StRun:   if (last_step) st_d = StDone;
            StDone:  if (out_ready) st_d = StIdle;
            default: st_d = StIdle;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (st_q)
            StIdle:  in_ready = ready_en_q;
            StRun:   ;
            StDone:  out_valid = 1'b1;
            default: ;
        endcase
    end

    // One digit of ripple addition; carry_chain[DIGIT-1] is the carry into the
    // digit's top bit, which on the last step is the carry into the MSB.
    always_comb begin
        carry_chain    = '0;
        sum_dig        = '0;
        carry_chain[0] = carry_q;
        for (int i = 0; i < int'(DIGIT); i++) begin
            sum_dig[i]       = a_q[i] ^ b_q[i] ^ carry_chain[i];
            carry_chain[i+1] = (a_q[i] & b_q[i]) | (carry_chain[i] & (a_q[i] ^ b_q[i]));
        end
        a_shift                   = a_q >> DIGIT;
        a_shift[WIDTH-1 -: DIGIT] = sum_dig;
    end

    // Datapath next-state: capture, shift per RUN step, latch result on the last step.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        step_d  = step_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        if (capture) begin
            a_d     = a;
            b_d     = sub ? ~b : b;
            carry_d = cin ^ sub;  // a - b - cin == a + ~b + ~cin
            step_d  = '0;
        end else if (st_q == StRun) begin
            a_d     = a_shift;
            b_d     = b_q >> DIGIT;
            carry_d = carry_chain[DIGIT];
            step_d  = step_q + StepW'(1);
            if (last_step) begin
                s_d    = a_shift;
                cout_d = carry_chain[DIGIT];
                ovf_d  = carry_chain[DIGIT-1] ^ carry_chain[DIGIT];
            end
        end
    end

    // Datapath registers, cleared asynchronously so a reset abandons any operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            step_q  <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            step_q  <= step_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign s    = s_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: one instance with DIGIT=1 and one with DIGIT=4.
module tb_serial_adder;

    logic       clk;
    logic       rst_n;
    logic [1:0] in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [7:0] a_v [2];
    logic [7:0] b_v [2];
    logic [7:0] s_v [2];

    int n_vec  = 0;
    int n_miss = 0;

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a_v[0]), .b(b_v[0]), .cin(cin[0]), .sub(sub[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .s(s_v[0]), .cout(cout[0]), .ovf(ovf[0])
    );

    serial_adder #(.WIDTH(8), .DIGIT(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a_v[1]), .b(b_v[1]), .cin(cin[1]), .sub(sub[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .s(s_v[1]), .cout(cout[1]), .ovf(ovf[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one operand bundle, wait for the result, check it, then handshake.
    task automatic do_op(input int u, input logic [7:0] ai, input logic [7:0] bi,
                         input logic ci, input logic si, input logic [7:0] es,
                         input logic ec, input logic eo, input int lat, input string tag);
        int cyc;
        @(posedge clk); #1;
        chk({tag, "_in_ready"}, 32'(in_ready[u]), 32'd1);
        a_v[u] = ai; b_v[u] = bi; cin[u] = ci; sub[u] = si; in_valid[u] = 1'b1;
        @(posedge clk); #1;
        in_valid[u] = 1'b0;
        cyc = 0;
        while (!out_valid[u] && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_latency"}, 32'(cyc), 32'(lat));
        chk({tag, "_s"}, 32'(s_v[u]), 32'(es));
        chk({tag, "_cout"}, 32'(cout[u]), 32'(ec));
        chk({tag, "_ovf"}, 32'(ovf[u]), 32'(eo));
        out_ready[u] = 1'b1;
        @(posedge clk); #1;
        out_ready[u] = 1'b0;
        chk({tag, "_out_valid_drop"}, 32'(out_valid[u]), 32'd0);
        chk({tag, "_in_ready_back"}, 32'(in_ready[u]), 32'd1);
    endtask

    initial begin
        int cyc;
        int nvalid;
        rst_n = 1'b0;
        in_valid = '0; cin = '0; sub = '0; out_ready = '0;
        a_v[0] = '0; a_v[1] = '0; b_v[0] = '0; b_v[1] = '0;

        // Reset state
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_s1", 32'(s_v[0]), 32'd0);
        @(posedge clk); #1;
        chk("rst_in_ready_clk", 32'(in_ready), 32'd0);
        #6 rst_n = 1'b1;
        #1;
        chk("rel_in_ready_pre_edge", 32'(in_ready), 32'd0);

        // Arithmetic vectors, DIGIT=1
        do_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8, "add_ff_01");
        do_op(0, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 8, "add_7f_01");
        do_op(0, 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 8, "sub_05_07");
        do_op(0, 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 8, "sub_80_01");
        do_op(0, 8'h40, 8'h3F, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1, 8, "add_40_3f_c");

        // DIGIT=4
        do_op(1, 8'h3C, 8'hC4, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 2, "d4_add_3c_c4");
        do_op(1, 8'h10, 8'h01, 1'b1, 1'b1, 8'h0E, 1'b1, 1'b0, 2, "d4_sub_10_01_b");

        // Backpressure: C0 + A0 = 160 -> s=60, cout=1, ovf=1
        @(posedge clk); #1;
        a_v[0] = 8'hC0; b_v[0] = 8'hA0; cin[0] = 1'b0; sub[0] = 1'b0; in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        cyc = 0;
        while (!out_valid[0] && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("bp_latency", 32'(cyc), 32'd8);
        for (int i = 0; i < 5; i++) begin
            in_valid[0] = ~in_valid[0];
            a_v[0] = a_v[0] + 8'h11;
            b_v[0] = ~b_v[0];
            sub[0] = ~sub[0];
            @(posedge clk); #1;
            chk("bp_s", 32'(s_v[0]), 32'h60);
            chk("bp_cout", 32'(cout[0]), 32'd1);
            chk("bp_ovf", 32'(ovf[0]), 32'd1);
            chk("bp_in_ready", 32'(in_ready[0]), 32'd0);
            chk("bp_out_valid", 32'(out_valid[0]), 32'd1);
        end
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        chk("bp_handshake", 32'(out_valid[0]), 32'd0);
        @(posedge clk); #1;
        chk("bp_single_handshake", 32'(out_valid[0]), 32'd0);
        chk("bp_idle_ready", 32'(in_ready[0]), 32'd1);
        out_ready[0] = 1'b0;

        // Reset in RUN cycle 3
        @(posedge clk); #1;
        a_v[0] = 8'hFF; b_v[0] = 8'h01; cin[0] = 1'b0; sub[0] = 1'b0; in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready", 32'(in_ready[0]), 32'd0);
        chk("arst_out_valid", 32'(out_valid[0]), 32'd0);
        chk("arst_s", 32'(s_v[0]), 32'h00);
        chk("arst_cout", 32'(cout[0]), 32'd0);
        chk("arst_ovf", 32'(ovf[0]), 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        chk("arst_rel_in_ready", 32'(in_ready[0]), 32'd0);
        nvalid = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid[0]) nvalid++;
        end
        chk("arst_no_stale_valid", 32'(nvalid), 32'd0);
        chk("arst_ready_after", 32'(in_ready[0]), 32'd1);
        do_op(0, 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 8, "post_rst_sub");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits; SHALL be ≥2.
REQ-002 Parameter DIGIT, default 1, bits processed per cycle; SHALL divide WIDTH exactly, else elaboration fails.
REQ-003 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous and active-low; deassertion SHALL be synchronised to clk by the integrator.
REQ-005 in_valid  in  1  operand bundle (a, b, cin, sub) is valid.
REQ-006 in_ready  out  1  block can accept an operand bundle.
REQ-007 a  in  WIDTH  operand A, unsigned or two's complement.
REQ-008 b  in  WIDTH  operand B.
REQ-009 cin  in  1  carry-in for add; borrow-in for subtract.
REQ-010 sub  in  1  0 = add, 1 = subtract.
REQ-011 out_valid  out  1  result bundle is valid.
REQ-012 out_ready  in  1  consumer accepts result.
REQ-013 s  out  WIDTH  sum or difference.
REQ-014 cout  out  1  carry-out for add; inverted borrow (1 = no borrow) for subtract.
REQ-015 ovf  out  1  signed two's-complement overflow.

Function
REQ-016 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-017 IDLE: in_ready=1; in_valid=1 SHALL capture a, b, cin, sub into internal registers and enter RUN.
REQ-018 Capture, add: B' = b, carry = cin. Capture, sub: B' = ~b, carry = ~cin, giving a − b − cin.
REQ-019 RUN: each cycle adds DIGIT LSB-first bits of A and B' plus the carry register, writes DIGIT result bits, and updates the carry register; the operand registers shift right by DIGIT.
REQ-020 RUN SHALL last exactly WIDTH/DIGIT cycles, tracked by a step counter of width clog2(WIDTH/DIGIT+1), cleared on capture.
REQ-021 On the last RUN cycle: cout = final carry; ovf = carry into MSB XOR carry out of MSB. Enter DONE.
REQ-022 Latency: out_valid SHALL rise WIDTH/DIGIT cycles after the capture edge.
REQ-023 in_ready SHALL be 0 in RUN and DONE; in_valid there SHALL be ignored and SHALL NOT corrupt the operation.
REQ-024 DONE: out_valid=1; s, cout, ovf SHALL be held stable until out_valid·out_ready.
REQ-025 On out_valid·out_ready the FSM SHALL return to IDLE; the new operand is accepted no earlier than the next cycle (no same-cycle pass-through).
REQ-026 out_ready may be asserted before out_valid; only a DONE-state handshake is meaningful.
REQ-027 s, cout, ovf SHALL be undefined-free (retain last value) outside DONE; consumers SHALL sample them only while out_valid=1.
REQ-028 Result SHALL equal (a + b + cin) mod 2^WIDTH for add and (a − b − cin) mod 2^WIDTH for subtract, for every DIGIT.

Reset
REQ-029 rst_n=0 SHALL force IDLE immediately, regardless of clock, and clear step counter, carry, operand registers, s, cout and ovf to 0.
REQ-030 During reset: in_ready=0, out_valid=0. in_ready=1 from the first clk edge after deassertion.
REQ-031 Reset asserted in RUN or DONE SHALL abandon the operation; no out_valid for it after release.

Verification
REQ-032 WIDTH=8, DIGIT=1, add a=FF b=01 cin=0 -> s=00, cout=1, ovf=0, out_valid exactly 8 cycles after capture.
REQ-033 WIDTH=8, DIGIT=1, add a=7F b=01 cin=0 -> s=80, cout=0, ovf=1.
REQ-034 WIDTH=8, DIGIT=1, sub a=05 b=07 cin=0 -> s=FE, cout=0, ovf=0; sub a=80 b=01 cin=0 -> s=7F, cout=1, ovf=1.
REQ-035 WIDTH=8, DIGIT=4, add a=3C b=C4 cin=1 -> s=01, cout=1, ovf=0, out_valid 2 cycles after capture.
REQ-036 Backpressure: hold out_ready=0 for 5 cycles in DONE, toggling in_valid and operands -> s, cout and ovf stable, in_ready=0 throughout, and one handshake on out_ready=1.
REQ-037 Assert rst_n=0 on RUN cycle 3 -> outputs cleared asynchronously, in_ready=0 during reset; after release the next operand gives a correct result and no stale out_valid appears.
